muxn_pipe: RTL and testbench



---
 rtl/muxn_pipe_if.sv | 27 ++
 rtl/muxn_pipe.sv | 76 +++++++
 tb/tb_muxn_pipe.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/muxn_pipe_if.sv
// Handshake bundle for muxn_pipe: packed channels and select in, registered result out.
// slave = selector side, master = the surrounding datapath/testbench.
interface muxn_pipe_if #(
  parameter int WIDTH = 32,
  parameter int N     = 4
);
  localparam int SELW = ($clog2(N) > 1) ? $clog2(N) : 1;

  logic [N*WIDTH-1:0] d_flat;
  logic [SELW-1:0]    sel;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   y;
  logic               out_valid;
  logic               out_ready;
  logic               sel_err;

  modport master (
    output d_flat, sel, in_valid, out_ready,
    input  in_ready, y, out_valid, sel_err
  );

  modport slave (
    input  d_flat, sel, in_valid, out_ready,
    output in_ready, y, out_valid, sel_err
  );
endinterface

// File: rtl/muxn_pipe.sv
// N-way selector with a registered output and a one-entry skid buffer on a valid/ready link.
// Define MUXN_SEL_ERR_EN to build the sticky illegal-select flag (sel_err); otherwise it is tied 0.
module muxn_pipe #(
  parameter int WIDTH = 32,
  parameter int N     = 4
) (
  input logic         clk,
  input logic         rst_n,
  muxn_pipe_if.slave  bus
);
  localparam int SELW = ($clog2(N) > 1) ? $clog2(N) : 1;

  logic [WIDTH-1:0] sel_val;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;
  logic             main_valid;
  logic             skid_valid;
  logic             accept;
  logic             out_xfer;

  // Encodings at or above N match no channel and leave the zero default.
  always_comb begin
    sel_val = '0;
    for (int k = 0; k < N; k++) begin
      if (bus.sel == SELW'(k)) sel_val = bus.d_flat[k*WIDTH +: WIDTH];
    end
  end

  assign accept   = bus.in_valid & ~skid_valid;
  assign out_xfer = main_valid & bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data  <= '0;
      main_valid <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
    end else if (accept) begin
      // Skid is always empty here since in_ready is its complement.
      if (!main_valid || bus.out_ready) begin
        main_data  <= sel_val;
        main_valid <= 1'b1;
      end else begin
        skid_data  <= sel_val;
        skid_valid <= 1'b1;
      end
    end else if (out_xfer) begin
      if (skid_valid) begin
        main_data  <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        main_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = ~skid_valid;
  assign bus.y         = main_data;
  assign bus.out_valid = main_valid;

`ifdef MUXN_SEL_ERR_EN
  logic sel_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
    end else if (accept && ({1'b0, bus.sel} >= (SELW+1)'(N))) begin
      sel_err_q <= 1'b1;
    end
  end

  assign bus.sel_err = sel_err_q;
`else
  assign bus.sel_err = 1'b0;
`endif
endmodule

// File: tb/tb_muxn_pipe.sv
// Self-checking bench for muxn_pipe: directed N=4 and N=3 cases, then a random N=16 stream
// checked against a queue-based reference of the selector's FIFO behaviour.
module tb_muxn_pipe;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [31:0] q4[$];
  logic [31:0] q16[$];

`ifdef MUXN_SEL_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  muxn_pipe_if #(.WIDTH(32), .N(4))  if4  ();
  muxn_pipe_if #(.WIDTH(32), .N(3))  if3  ();
  muxn_pipe_if #(.WIDTH(32), .N(16)) if16 ();

  muxn_pipe #(.WIDTH(32), .N(4))  u4  (.clk(clk), .rst_n(rst_n), .bus(if4));
  muxn_pipe #(.WIDTH(32), .N(3))  u3  (.clk(clk), .rst_n(rst_n), .bus(if3));
  muxn_pipe #(.WIDTH(32), .N(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ch4(input logic [1:0] s);
    return if4.d_flat[s*32 +: 32];
  endfunction

  function automatic logic [31:0] ch3(input logic [1:0] s);
    return (s < 2'd3) ? if3.d_flat[s*32 +: 32] : 32'h0;
  endfunction

  // One cycle on the N=4 instance: check against the queue, drive, advance the model.
  task automatic cyc4(input logic iv, input logic [1:0] s, input logic ordy);
    logic acc;
    logic ox;
    chk("n4_out_valid", if4.out_valid, q4.size() > 0);
    chk("n4_in_ready", if4.in_ready, q4.size() < 2);
    if (q4.size() > 0) chk("n4_y", if4.y, q4[0]);
    if4.in_valid  = iv;
    if4.sel       = s;
    if4.out_ready = ordy;
    acc = iv && (q4.size() < 2);
    ox  = ordy && (q4.size() > 0);
    if (ox) void'(q4.pop_front());
    if (acc) q4.push_back(ch4(s));
    @(negedge clk);
  endtask

  initial begin
    int done;
    int cyc;
    logic prev_hold;
    logic [3:0] s16;
    logic acc;
    logic ox;

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    if4.d_flat = {32'h44, 32'h33, 32'h22, 32'h11};
    if4.sel = '0; if4.in_valid = 1'b0; if4.out_ready = 1'b0;
    if3.d_flat = {32'hCC, 32'hBB, 32'hAA};
    if3.sel = '0; if3.in_valid = 1'b0; if3.out_ready = 1'b1;
    if16.d_flat = '0;
    if16.sel = '0; if16.in_valid = 1'b0; if16.out_ready = 1'b0;

    @(negedge clk);
    chk("rst_out_valid", if4.out_valid, 1'b0);
    chk("rst_in_ready", if4.in_ready, 1'b1);
    chk("rst_y", if4.y, 32'h0);
    chk("rst_sel_err", if4.sel_err, 1'b0);
    rst_n = 1'b1;

    // Single select, then streaming at full rate
    cyc4(1'b1, 2'd2, 1'b1);
    chk("t1_y", if4.y, 32'h33);
    cyc4(1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 4; i++) cyc4(1'b1, 2'(i), 1'b1);
    cyc4(1'b0, 2'd0, 1'b1);
    cyc4(1'b0, 2'd0, 1'b1);

    // Stall: fill main and skid, hold, then drain in order
    cyc4(1'b1, 2'd1, 1'b0);
    cyc4(1'b1, 2'd3, 1'b0);
    chk("t3_full", if4.in_ready, 1'b0);
    cyc4(1'b1, 2'd0, 1'b0);
    cyc4(1'b0, 2'd0, 1'b0);
    chk("t3_hold_y", if4.y, 32'h22);
    cyc4(1'b0, 2'd0, 1'b1);
    chk("t3_second", if4.y, 32'h44);
    cyc4(1'b0, 2'd0, 1'b1);
    cyc4(1'b0, 2'd0, 1'b1);

    // Async reset while full
    cyc4(1'b1, 2'd1, 1'b0);
    cyc4(1'b1, 2'd3, 1'b0);
    if4.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t5_out_valid", if4.out_valid, 1'b0);
    chk("t5_y", if4.y, 32'h0);
    chk("t5_in_ready", if4.in_ready, 1'b1);
    q4.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cyc4(1'b1, 2'd2, 1'b1);
    chk("t5_after", if4.y, 32'h33);
    cyc4(1'b0, 2'd0, 1'b1);
    cyc4(1'b0, 2'd0, 1'b1);

    // N=3 illegal select and sticky flag
    chk("t4_err_init", if3.sel_err, 1'b0);
    if3.in_valid = 1'b1;
    if3.sel      = 2'd3;
    @(negedge clk);
    chk("t4_zero", if3.y, 32'h0);
    chk("t4_valid", if3.out_valid, 1'b1);
    chk("t4_err", if3.sel_err, EXP_ERR);
    for (int i = 0; i < 10; i++) begin
      if3.sel = 2'(i % 3);
      @(negedge clk);
      chk("t4_legal_y", if3.y, ch3(2'(i % 3)));
      chk("t4_sticky", if3.sel_err, EXP_ERR);
    end
    if3.in_valid = 1'b0;
    @(negedge clk);
    chk("t4_drained", if3.out_valid, 1'b0);

    // Random N=16 stream against the queue model
    done = 0;
    cyc = 0;
    prev_hold = 1'b0;
    while (done < 1000 && cyc < 20000) begin
      chk("n16_out_valid", if16.out_valid, q16.size() > 0);
      chk("n16_in_ready", if16.in_ready, q16.size() < 2);
      if (q16.size() > 0) chk("n16_y", if16.y, q16[0]);
      if (prev_hold) chk("n16_no_drop", if16.out_valid, 1'b1);
      for (int k = 0; k < 16; k++) if16.d_flat[k*32 +: 32] = $urandom();
      s16 = 4'($urandom_range(0, 15));
      if16.sel       = s16;
      if16.in_valid  = ($urandom_range(0, 3) != 0);
      if16.out_ready = ($urandom_range(0, 2) != 0);
      acc = if16.in_valid && (q16.size() < 2);
      ox  = if16.out_ready && (q16.size() > 0);
      prev_hold = (q16.size() > 0) && !if16.out_ready;
      if (ox) begin
        void'(q16.pop_front());
        done++;
      end
      if (acc) q16.push_back(if16.d_flat[s16*32 +: 32]);
      @(negedge clk);
      cyc++;
    end
    chk("n16_completed", done >= 1000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
